// File: rtl/pru1_memoria_arbiter.sv
// Two-master arbiter for the single-port 1024x32 RAM: grants one command per cycle,
// muxes it onto the RAM port and steers the 1-cycle-latency read data back to its issuer.
module pru1_memoria_arbiter #(
   parameter int PRIORITY_MODE = 0,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  m0_address,
   input  logic [3:0]  m0_byteenable,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,
   input  logic [9:0]  m1_address,
   input  logic [3:0]  m1_byteenable,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,
   output logic [9:0]  mem_address,
   output logic [3:0]  mem_byteenable,
   output logic        mem_chipselect,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   output logic        grant_id
);

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic       req0, req1;
   logic       g0, g1;
   logic       last_grant_q, last_grant_d;
   logic       grant_id_q, grant_id_d;
   logic       rd_pend_q, rd_pend_d;
   logic       rd_id_q, rd_id_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // Grants are suppressed while reset is high so the RAM port goes quiet immediately.
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (!reset) begin
         if (req0 && !req1) begin
            g0 = 1'b1;
         end else if (!req0 && req1) begin
            g1 = 1'b1;
         end else if (req0 && req1) begin
            if (PRIORITY_MODE == 0) begin
               g0 = last_grant_q;
               g1 = ~last_grant_q;
            end else begin
               g1 = (starve_cnt_q == STARVE_MAX);
               g0 = ~g1;
            end
         end
      end
   end

   assign m0_waitrequest = req0 & ~g0;
   assign m1_waitrequest = req1 & ~g1;

   assign mem_chipselect = g0 | g1;

   always_comb begin
      mem_address    = '0;
      mem_byteenable = '0;
      mem_write      = 1'b0;
      mem_writedata  = '0;
      if (g0) begin
         mem_address    = m0_address;
         mem_byteenable = m0_byteenable;
         mem_write      = m0_write;
         mem_writedata  = m0_writedata;
      end else if (g1) begin
         mem_address    = m1_address;
         mem_byteenable = m1_byteenable;
         mem_write      = m1_write;
         mem_writedata  = m1_writedata;
      end
   end

   // Write wins when a master raises read and write together.
   always_comb begin
      rd_pend_d    = (g0 & m0_read & ~m0_write) | (g1 & m1_read & ~m1_write);
      rd_id_d      = g1;
      last_grant_d = (g0 | g1) ? g1 : last_grant_q;
      grant_id_d   = (g0 | g1) ? g1 : grant_id_q;
      starve_cnt_d = 4'd0;
      if (req1 && !g1) begin
         starve_cnt_d = (starve_cnt_q >= STARVE_MAX) ? STARVE_MAX : starve_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         grant_id_q   <= 1'b0;
         rd_pend_q    <= 1'b0;
         rd_id_q      <= 1'b0;
         starve_cnt_q <= 4'd0;
      end else begin
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         rd_pend_q    <= rd_pend_d;
         rd_id_q      <= rd_id_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign m0_readdatavalid = rd_pend_q & ~rd_id_q;
   assign m1_readdatavalid = rd_pend_q & rd_id_q;
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign grant_id         = grant_id_q;

endmodule

// File: tb/tb_pru1_memoria_arbiter.sv
// Bench for pru1_memoria_arbiter: one round-robin and one fixed-priority instance driven by
// the same masters, each with its own RAM; read data is checked through a per-master scoreboard.
module tb_pru1_memoria_arbiter;

   localparam int STARVE = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;

   logic        m0_wait_o [2];
   logic        m1_wait_o [2];
   logic [31:0] m0_rd_o [2];
   logic [31:0] m1_rd_o [2];
   logic        m0_rdv_o [2];
   logic        m1_rdv_o [2];
   logic [9:0]  mem_addr_o [2];
   logic [3:0]  mem_be_o [2];
   logic        mem_cs_o [2];
   logic        mem_we_o [2];
   logic [31:0] mem_wd_o [2];
   logic [31:0] mem_rd_i [2];
   logic        gid_o [2];

   int errors = 0;
   int checks = 0;

   logic [31:0] q [4][$];
   logic [31:0] shadow [2][1024];
   int rr_last, st_cnt;
   int gid [2];
   int obs_w [2];
   logic obs_wait1 [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [31:0] ram [1024];

      pru1_memoria_arbiter #(.PRIORITY_MODE(g), .STARVE_LIMIT(STARVE)) u_dut (
         .clk(clk), .reset(reset),
         .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
         .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_wait_o[g]),
         .m0_readdata(m0_rd_o[g]), .m0_readdatavalid(m0_rdv_o[g]),
         .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
         .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_wait_o[g]),
         .m1_readdata(m1_rd_o[g]), .m1_readdatavalid(m1_rdv_o[g]),
         .mem_address(mem_addr_o[g]), .mem_byteenable(mem_be_o[g]), .mem_chipselect(mem_cs_o[g]),
         .mem_write(mem_we_o[g]), .mem_writedata(mem_wd_o[g]), .mem_readdata(mem_rd_i[g]),
         .grant_id(gid_o[g])
      );

      initial begin
         for (int a = 0; a < 1024; a++) ram[a] = 32'h0;
         mem_rd_i[g] = 32'h0;
      end

      always @(posedge clk) begin
         if (mem_cs_o[g]) begin
            if (mem_we_o[g]) begin
               for (int b = 0; b < 4; b++)
                  if (mem_be_o[g][b]) ram[mem_addr_o[g]][8*b +: 8] <= mem_wd_o[g][8*b +: 8];
            end else begin
               mem_rd_i[g] <= ram[mem_addr_o[g]];
            end
         end
      end
   end

   // Read-return monitor: every valid beat must match the oldest outstanding expectation.
   always @(negedge clk) begin : mon
      logic v;
      logic [31:0] d, e;
      for (int i = 0; i < 2; i++) begin
         for (int m = 0; m < 2; m++) begin
            v = (m == 0) ? m0_rdv_o[i] : m1_rdv_o[i];
            d = (m == 0) ? m0_rd_o[i] : m1_rd_o[i];
            if (v === 1'b1) begin
               checks++;
               if (q[i*2+m].size() == 0) begin
                  errors++;
                  $display("FAIL rdata_unexpected inst%0d m%0d: got valid data %h, expected no beat", i, m, d);
               end else begin
                  e = q[i*2+m].pop_front();
                  if (d !== e) begin
                     errors++;
                     $display("FAIL rdata inst%0d m%0d: got %h expected %h", i, m, d, e);
                  end
               end
            end
         end
      end
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic idle();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
      m0_address = '0; m1_address = '0; m0_byteenable = '0; m1_byteenable = '0;
      m0_writedata = '0; m1_writedata = '0;
   endtask

   task automatic model_reset();
      rr_last = 1; st_cnt = 0; gid[0] = 0; gid[1] = 0;
      for (int k = 0; k < 4; k++) q[k].delete();
   endtask

   // One clock: predict the grant for each instance, check the port, queue expected read data.
   task automatic step();
      logic r0, r1, wr;
      int w [2];
      logic [9:0] a;
      logic [3:0] be;
      logic [31:0] wd;
      @(negedge clk);
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      if (r0 && r1) begin
         w[0] = (rr_last == 1) ? 0 : 1;
         w[1] = (st_cnt == STARVE) ? 1 : 0;
      end else if (r0) begin
         w[0] = 0; w[1] = 0;
      end else if (r1) begin
         w[0] = 1; w[1] = 1;
      end else begin
         w[0] = -1; w[1] = -1;
      end
      for (int i = 0; i < 2; i++) begin
         obs_w[i] = (mem_cs_o[i] !== 1'b1) ? -1 : ((r0 && m0_wait_o[i] === 1'b0) ? 0 : 1);
         obs_wait1[i] = m1_wait_o[i];
         checks++;
         if (m0_wait_o[i] !== (r0 && w[i] != 0)) begin
            errors++;
            $display("FAIL waitreq0 inst%0d: got %b expected %b", i, m0_wait_o[i], (r0 && w[i] != 0));
         end
         checks++;
         if (m1_wait_o[i] !== (r1 && w[i] != 1)) begin
            errors++;
            $display("FAIL waitreq1 inst%0d: got %b expected %b", i, m1_wait_o[i], (r1 && w[i] != 1));
         end
         checks++;
         if (mem_cs_o[i] !== (w[i] >= 0)) begin
            errors++;
            $display("FAIL chipselect inst%0d: got %b expected %b", i, mem_cs_o[i], (w[i] >= 0));
         end
         checks++;
         if (gid_o[i] !== gid[i][0]) begin
            errors++;
            $display("FAIL grant_id inst%0d: got %b expected %0d", i, gid_o[i], gid[i]);
         end
         if (w[i] >= 0) begin
            wr = (w[i] == 0) ? m0_write : m1_write;
            a  = (w[i] == 0) ? m0_address : m1_address;
            be = (w[i] == 0) ? m0_byteenable : m1_byteenable;
            wd = (w[i] == 0) ? m0_writedata : m1_writedata;
            checks++;
            if (mem_addr_o[i] !== a || mem_we_o[i] !== wr) begin
               errors++;
               $display("FAIL mem_cmd inst%0d: got addr %h we %b expected addr %h we %b",
                        i, mem_addr_o[i], mem_we_o[i], a, wr);
            end
            if (wr) begin
               checks++;
               if (mem_wd_o[i] !== wd || mem_be_o[i] !== be) begin
                  errors++;
                  $display("FAIL mem_wdata inst%0d: got %h/%h expected %h/%h",
                           i, mem_wd_o[i], mem_be_o[i], wd, be);
               end
               shadow[i][a] = merge(shadow[i][a], wd, be);
            end else begin
               q[i*2+w[i]].push_back(shadow[i][a]);
            end
         end else begin
            checks++;
            if (mem_addr_o[i] !== 10'h0 || mem_we_o[i] !== 1'b0 || mem_wd_o[i] !== 32'h0) begin
               errors++;
               $display("FAIL mem_idle inst%0d: got addr %h we %b wd %h expected all zero",
                        i, mem_addr_o[i], mem_we_o[i], mem_wd_o[i]);
            end
         end
      end
      @(posedge clk);
      if (w[0] >= 0) rr_last = w[0];
      if (r1 && w[1] != 1) begin
         if (st_cnt < STARVE) st_cnt++;
      end else begin
         st_cnt = 0;
      end
      for (int i = 0; i < 2; i++) if (w[i] >= 0) gid[i] = w[i];
      #1;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      m0_read = 1; m0_address = 10'h005;
      repeat (2) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (m0_wait_o[i] !== 1'b1 || mem_cs_o[i] !== 1'b0 || m0_rdv_o[i] !== 1'b0 ||
                m1_rdv_o[i] !== 1'b0 || gid_o[i] !== 1'b0) begin
               errors++;
               $display("FAIL reset_state inst%0d: got wait0 %b cs %b rdv %b/%b gid %b expected 1 0 0/0 0",
                        i, m0_wait_o[i], mem_cs_o[i], m0_rdv_o[i], m1_rdv_o[i], gid_o[i]);
            end
         end
      end
      @(posedge clk); #1;
      idle();
      reset = 0;
      model_reset();
   endtask

   task automatic test_write_read();
      m0_write = 1; m0_address = 10'h005; m0_byteenable = 4'hF; m0_writedata = 32'hDEADBEEF;
      step();
      idle();
      m0_read = 1; m0_address = 10'h005;
      step();
      idle();
      checks++;
      if (m0_rdv_o[0] !== 1'b1 || m0_rd_o[0] !== 32'hDEADBEEF || m1_rdv_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL write_read: got rdv0 %b data %h rdv1 %b expected 1 deadbeef 0",
                  m0_rdv_o[0], m0_rd_o[0], m1_rdv_o[0]);
      end
      step();
   endtask

   task automatic test_round_robin();
      m0_write = 1; m0_address = 10'h010; m0_byteenable = 4'hF; m0_writedata = 32'h1010_1010;
      step();
      idle();
      m1_write = 1; m1_address = 10'h020; m1_byteenable = 4'hF; m1_writedata = 32'h2020_2020;
      step();
      idle();
      step();
      m0_read = 1; m0_address = 10'h010;
      m1_read = 1; m1_address = 10'h020;
      for (int k = 0; k < 6; k++) begin
         step();
         checks++;
         if (obs_w[0] !== (k % 2)) begin
            errors++;
            $display("FAIL rr_order cycle %0d: got winner %0d expected %0d", k, obs_w[0], k % 2);
         end
      end
      idle();
      step();
   endtask

   task automatic test_priority();
      int run;
      run = 0;
      m0_read = 1; m0_address = 10'h010;
      m1_read = 1; m1_address = 10'h020;
      for (int k = 0; k < 10; k++) begin
         step();
         if (k < 5 && obs_wait1[1] === 1'b1) run++;
         checks++;
         if (obs_w[1] !== (((k % 5) == 4) ? 1 : 0)) begin
            errors++;
            $display("FAIL prio_order cycle %0d: got winner %0d expected %0d",
                     k, obs_w[1], ((k % 5) == 4) ? 1 : 0);
         end
      end
      checks++;
      if (run !== STARVE) begin
         errors++;
         $display("FAIL starve_run: got %0d waiting cycles expected %0d", run, STARVE);
      end
      idle();
      step();
   endtask

   task automatic test_byte_write();
      m1_write = 1; m1_address = 10'h3FF; m1_byteenable = 4'hF; m1_writedata = 32'hFFFF_FFFF;
      step();
      m1_writedata = 32'h1122_3344; m1_byteenable = 4'h5;
      step();
      idle();
      m1_read = 1; m1_address = 10'h3FF;
      step();
      idle();
      checks++;
      if (m1_rdv_o[0] !== 1'b1 || m1_rd_o[0] !== 32'hFF22_FF44) begin
         errors++;
         $display("FAIL byte_write: got rdv %b data %h expected 1 ff22ff44", m1_rdv_o[0], m1_rd_o[0]);
      end
      step();
   endtask

   task automatic test_write_then_read();
      m0_write = 1; m0_address = 10'h100; m0_byteenable = 4'hF; m0_writedata = 32'hA5A5_A5A5;
      step();
      idle();
      m1_read = 1; m1_address = 10'h100;
      step();
      idle();
      checks++;
      if (m1_rdv_o[1] !== 1'b1 || m1_rd_o[1] !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL wr_then_rd: got rdv %b data %h expected 1 a5a5a5a5", m1_rdv_o[1], m1_rd_o[1]);
      end
      step();
   endtask

   task automatic test_reset_outstanding();
      m0_read = 1; m0_address = 10'h005;
      step();
      idle();
      reset = 1;
      model_reset();
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (m0_rdv_o[i] !== 1'b0 || mem_cs_o[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop inst%0d: got rdv %b cs %b expected 0 0", i, m0_rdv_o[i], mem_cs_o[i]);
         end
      end
      @(posedge clk); #1;
      m1_read = 1; m1_address = 10'h100;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (m0_rdv_o[i] !== 1'b0 || m1_wait_o[i] !== 1'b1 || gid_o[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold inst%0d: got rdv %b wait1 %b gid %b expected 0 1 0",
                     i, m0_rdv_o[i], m1_wait_o[i], gid_o[i]);
         end
      end
      reset = 0;
      step();
      idle();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs_w[i] !== 1 || m1_rdv_o[i] !== 1'b1 || m1_rd_o[i] !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL post_reset inst%0d: got winner %0d rdv %b data %h expected 1 1 a5a5a5a5",
                     i, obs_w[i], m1_rdv_o[i], m1_rd_o[i]);
         end
      end
      step();
   endtask

   initial begin
      for (int i = 0; i < 2; i++) for (int a = 0; a < 1024; a++) shadow[i][a] = 32'h0;
      model_reset();
      test_reset();
      test_write_read();
      test_round_robin();
      test_priority();
      test_byte_write();
      test_write_then_read();
      test_reset_outstanding();
      step();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (q[k].size() != 0) begin
            errors++;
            $display("FAIL lost_reads queue %0d: got %0d undelivered expected 0", k, q[k].size());
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pru1_memoria_arbiter.md
Name: pru1_memoria_arbiter

Overview:
Two-requester arbiter that shares the single-port 1024x32 on-chip RAM (10-bit word address, 4-bit byteenable, 1-cycle read latency) between two Avalon-MM-style masters (m0, m1). It selects one requester per cycle, muxes that requester's command onto the RAM port and routes read data back to the requester that issued the read. It sits between the masters and the RAM's s1 slave and is the only driver of that slave.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority to m0 with a starvation guard for m1
STARVE_LIMIT, 4, PRIORITY_MODE=1 only: after m1 loses this many consecutive cycles, m1 gets the next grant (legal range 1..15)

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
m0_address  in  10  m0 word address
m0_byteenable  in  4  m0 byte lanes for writes
m0_read  in  1  m0 read request
m0_write  in  1  m0 write request
m0_writedata  in  32  m0 write data
m0_waitrequest  out  1  high = m0 command not accepted this cycle
m0_readdata  out  32  read data to m0
m0_readdatavalid  out  1  m0_readdata valid this cycle
m1_* (address, byteenable, read, write, writedata, waitrequest, readdata, readdatavalid)  same widths and meaning, for m1
mem_address  out  10  RAM address
mem_byteenable  out  4  RAM byteenable
mem_chipselect  out  1  RAM chipselect
mem_write  out  1  RAM write
mem_writedata  out  32  RAM write data
mem_readdata  in  32  RAM read data, valid one cycle after the read command
grant_id  out  1  registered id of the requester granted most recently

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, named reset.
- reqX = mX_read | mX_write. If read and write are both high, the command is treated as a write.
- Grant is combinational in the current cycle: at most one of g0/g1 is high, and a grant is given only to a requester with reqX=1. Throughput is 1 command per cycle, with no bubbles.
- Round-robin (PRIORITY_MODE=0): when only one requester is active, it wins. When both are active, the requester other than last_grant wins. last_grant resets to 1, so m0 wins the first tie.
- Fixed priority (PRIORITY_MODE=1): m0 wins ties unless starve_cnt == STARVE_LIMIT, in which case m1 wins.
  - starve_cnt (4-bit) increments when m1 requests and loses.
  - It clears to 0 when m1 is granted or m1 does not request.
  - It saturates at STARVE_LIMIT and resets to 0.
- mX_waitrequest = reqX & ~gX (combinational). A requester holds its command stable until waitrequest is low.
- RAM port:
  - mem_chipselect = g0|g1.
  - mem_write = winner is writing.
  - mem_address, mem_byteenable and mem_writedata are muxed from the winner.
  - With no grant, all mem_* outputs are 0.
- Read return:
  - Registered rd_pend (1 bit) and rd_id (1 bit) capture "winner issued a read" and the winner id at the edge that issues the command.
  - In the following cycle, mX_readdatavalid = rd_pend & (rd_id==X).
  - Both mX_readdata are driven from mem_readdata.
  - Back-to-back reads from alternating requesters return data in issue order, one per cycle.
- grant_id updates to the winner id on every cycle with a grant and holds otherwise. It resets to 0.
- Write followed next cycle by a read of the same address returns the new data; the RAM write completes before the next read samples.
- While reset is high, the block forces the following values asynchronously:
  - grants are forced off: waitrequest = reqX, mem_chipselect = 0;
  - rd_pend = 0, readdatavalid = 0;
  - starve_cnt = 0, last_grant = 1, grant_id = 0.
- If reset asserts while a read is outstanding, that read's readdatavalid is dropped and never delivered.
- After reset deasserts, arbitration resumes at the first rising edge.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 0x005 with be=0xF, then m0 reads 0x005 -> m0_waitrequest=0 both cycles; m0_readdatavalid=1 one cycle after the read with readdata=0xDEADBEEF; m1_readdatavalid stays 0.
- PRIORITY_MODE=0, m0 and m1 both read continuously (m0 addr 0x010, m1 addr 0x020) -> grants alternate m0,m1,m0,m1 starting with m0; readdatavalid alternates one cycle later with the matching data; grant_id toggles.
- PRIORITY_MODE=1, STARVE_LIMIT=4, both request every cycle -> pattern is m0 x4, m1 x1, repeating; m1_waitrequest is high for exactly 4 consecutive cycles.
- Byte write: m1 writes 0x11223344 with be=0x5 to addr 0x3FF, which already holds 0xFFFFFFFF, then reads it -> 0xFF22FF44 (wrap-edge address 0x3FF).
- m0 write 0xA5A5A5A5 to addr 0x100 in cycle N, m1 read of 0x100 in cycle N+1 -> m1 receives 0xA5A5A5A5.
- Reset asserted in the cycle after a granted m0 read -> m0_readdatavalid=0 immediately and stays 0; first request after reset is granted at the first edge.
